// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA data-memory port arbiter with locked DMA bursts and perf counters.
// Grant is combinational; the DMA starvation guard is compiled in by DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] cpu_xfers,
    output logic [31:0] dma_xfers,
    output logic [31:0] stall_cycles
);

    localparam logic       CPU_PRI   = 1'b0;
    localparam logic       DMA_OWN   = 1'b1;
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
        $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
    end
    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst
        $error("dmem_arbiter: BURST_MAX out of range 1..255");
    end

    logic        r_state;
    logic [7:0]  r_beat_cnt;
    logic [31:0] r_cpu_xfers;
    logic [31:0] r_dma_xfers;
    logic [31:0] r_stall_cycles;
    logic        w_forced;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_stall;
    logic [7:0]  w_beat_nxt;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
    logic [7:0] r_wait_cnt;

    assign w_forced = (r_state == CPU_PRI) && cpu_req && dma_req && (r_wait_cnt >= STARVE_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (w_dma_gnt) begin
            r_wait_cnt <= '0;
        end else if (dma_req) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    assign w_forced = 1'b0;
`endif

    // Outputs are gated by reset_n so the port is quiet while reset is held.
    assign w_cpu_gnt  = reset_n && (r_state == CPU_PRI) && cpu_req && !w_forced;
    assign w_dma_gnt  = reset_n && dma_req && ((r_state == DMA_OWN) || !cpu_req || w_forced);
    assign w_stall    = reset_n && cpu_req && !w_cpu_gnt;
    assign w_beat_nxt = r_beat_cnt + 8'd1;

    assign cpu_stall = w_stall;
    assign dma_gnt   = w_dma_gnt;
    assign mem_we    = (w_dma_gnt && dma_we) || (w_cpu_gnt && cpu_we);
    assign mem_addr  = w_dma_gnt ? dma_addr  : (w_cpu_gnt ? cpu_addr  : 32'd0);
    assign mem_wdata = w_dma_gnt ? dma_wdata : (w_cpu_gnt ? cpu_wdata : 32'd0);

    // The beat that opens a burst counts as beat 1, so a burst never exceeds BURST_MAX beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CPU_PRI;
            r_beat_cnt <= '0;
        end else if (r_state == CPU_PRI) begin
            if (w_dma_gnt && dma_lock && !w_forced && (BURST_LIM != 8'd1)) begin
                r_state    <= DMA_OWN;
                r_beat_cnt <= 8'd1;
            end
        end else if (!dma_req || !dma_lock || (w_beat_nxt == BURST_LIM)) begin
            r_state    <= CPU_PRI;
            r_beat_cnt <= '0;
        end else begin
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_xfers    <= '0;
            r_dma_xfers    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_cpu_gnt) r_cpu_xfers    <= r_cpu_xfers + 32'd1;
            if (w_dma_gnt) r_dma_xfers    <= r_dma_xfers + 32'd1;
            if (w_stall)   r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign cpu_xfers    = r_cpu_xfers;
    assign dma_xfers    = r_dma_xfers;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: DMA wait cycles before a forced grant, range 1..255.
REQ-002 SHALL have parameter BURST_MAX, default 16: maximum consecutive locked DMA beats, range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req / cpu_we  in  1 / 1  pipeline MEM-stage access valid / store.
REQ-006 cpu_addr / cpu_wdata  in  32 / 32  MEM-stage address / store data.
REQ-007 cpu_stall  out  1  pipeline holds its MEM stage and all earlier stages this cycle.
REQ-008 dma_req / dma_we / dma_lock  in  1 / 1 / 1  DMA access valid / write / keep grant for the next beat.
REQ-009 dma_addr / dma_wdata  in  32 / 32  DMA address / write data.
REQ-010 dma_gnt  out  1  DMA beat completes this cycle.
REQ-011 mem_we / mem_addr / mem_wdata  out  1 / 32 / 32  data-memory port.
REQ-012 cpu_xfers / dma_xfers / stall_cycles  out  32 each  performance counters.

Function
REQ-013 Grant SHALL be combinational from inputs and registered state; memory read data bypasses this block.
REQ-014 States: CPU_PRI and DMA_OWN; reset state is CPU_PRI.
REQ-015 In CPU_PRI, with cpu_req=1 and no forced grant: CPU wins, cpu_stall=0, dma_gnt=0.
REQ-016 In CPU_PRI, with cpu_req=0 and dma_req=1: dma_gnt=1.
- If dma_lock=1 also, next state is DMA_OWN.
REQ-017 In DMA_OWN, with dma_req=1: dma_gnt=1 and cpu_stall=cpu_req.
- Return to CPU_PRI after a beat with dma_lock=0, or on dma_req=0 (no grant that cycle).
REQ-018 beat_cnt (8-bit) SHALL count granted DMA beats in DMA_OWN.
- The granted beat that makes beat_cnt=BURST_MAX forces a return to CPU_PRI even if dma_lock=1.
- dma_gnt SHALL stay 0 for at least the following cycle if cpu_req=1.
- beat_cnt clears on every entry to CPU_PRI.
REQ-019 mem_we/mem_addr/mem_wdata SHALL mux the granted requester's signals.
- With no grant: mem_we=0 and mem_addr/mem_wdata=0.
- mem_we never asserts without a grant.
REQ-020 cpu_stall SHALL be 0 whenever cpu_req=0.
REQ-021 cpu_xfers SHALL increment on each CPU-granted cycle; wraps 0xFFFFFFFF to 0.
REQ-022 dma_xfers SHALL increment on each cycle with dma_gnt=1; wraps 0xFFFFFFFF to 0.
REQ-023 stall_cycles SHALL increment on each cycle with cpu_stall=1; wraps 0xFFFFFFFF to 0.
REQ-024 dma_req falling mid-burst: no grant that cycle, state returns to CPU_PRI, no error.

Reset
REQ-025 reset_n low SHALL immediately force the following, independent of clk:
- CPU_PRI state.
- beat_cnt=0, wait_cnt=0.
- All three counters = 0.
REQ-026 During reset SHALL drive cpu_stall=0, dma_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-027 Reset mid-burst SHALL abandon the burst; the first cycle after release behaves as CPU_PRI.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_GUARD_EN SHALL compile in the starvation guard.
REQ-029 With the macro: 8-bit wait_cnt increments each cycle dma_req=1 and dma_gnt=0, and clears on dma_gnt=1.
- When wait_cnt=STARVE_LIMIT in CPU_PRI with both requests, DMA gets the grant: dma_gnt=1, cpu_stall=1.
- That forced grant SHALL NOT enter DMA_OWN, regardless of dma_lock.
REQ-030 Without the macro: no wait_cnt; CPU has strict priority in CPU_PRI and DMA may starve indefinitely.

Verification
REQ-031 CPU store cpu_addr=100, cpu_wdata=25, DMA idle -> same cycle mem_we=1, mem_addr=100, mem_wdata=25, cpu_stall=0; cpu_xfers=1 next cycle.
REQ-032 cpu_req=0, dma_req=1, dma_lock=1 for 4 beats (lock=0 on beat 4) with cpu_req=1 from beat 2 -> dma_gnt=1 for 4 cycles, cpu_stall=1 for 3, then CPU granted; stall_cycles=3.
REQ-033 BURST_MAX=16, dma_lock held high, cpu_req=1 -> exactly 16 DMA beats, then one CPU-granted cycle with dma_gnt=0.
REQ-034 Guard enabled, STARVE_LIMIT=8, cpu_req and dma_req held 1 -> dma_gnt=1 on the 9th cycle with cpu_stall=1, then CPU-granted for the next 8 cycles.
REQ-035 Guard disabled, same stimulus for 100 cycles -> dma_gnt never 1, dma_xfers=0.
REQ-036 reset_n pulsed low mid-edge during beat 3 of a locked burst -> outputs and counters 0 immediately; the first post-reset cycle with cpu_req=1 grants CPU.
